// File: rtl/dbg_bus_master_pkg.sv
// rtl/dbg_bus_master_pkg.sv - shared opcode, response, bus-mode and FSM-state constants
package dbg_bus_master_pkg;

  typedef logic [2:0] dbg_state_t;

  localparam logic [7:0] DBG_OP_READ  = 8'h52;
  localparam logic [7:0] DBG_OP_WRITE = 8'h57;
  localparam logic [7:0] DBG_RSP_ACK  = 8'h4B;
  localparam logic [7:0] DBG_RSP_ERR  = 8'h3F;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  localparam dbg_state_t ST_IDLE = 3'd0;
  localparam dbg_state_t ST_ADDR = 3'd1;
  localparam dbg_state_t ST_DATA = 3'd2;
  localparam dbg_state_t ST_BUS  = 3'd3;
  localparam dbg_state_t ST_RESP = 3'd4;

endpackage

// File: rtl/dbg_bus_master_resp_shifter.sv
// rtl/dbg_bus_master_resp_shifter.sv - response byte shifter, LSB first, ready/valid out
module dbg_resp_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;

  assign tx_valid = (cnt_q != 3'd0);
  assign tx_data  = data_q[7:0];
  assign last     = tx_valid && tx_ready && (cnt_q == 3'd1);

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = load_count;
    end else if (tx_valid && tx_ready) begin
      // zero-fill so tx_data returns to 0 once the queue drains
      data_d = {8'h00, data_q[31:8]};
      cnt_d  = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/dbg_bus_master.sv
// rtl/dbg_bus_master.sv - host byte-stream to single bus transaction debug initiator
module dbg_bus_master
  import dbg_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mst_address,
  output logic [31:0] mst_write_data,
  output logic [1:0]  mst_mode,
  input  logic [31:0] mst_read_data,
  output logic        busy,
  output logic        rx_overrun
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  dbg_state_t      state_q, state_d;
  logic            op_wr_q, op_wr_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ovr_q, ovr_d;

  logic            ld;
  logic [31:0]     ld_data;
  logic [2:0]      ld_cnt;
  logic            tx_last;

  assign busy           = (state_q != ST_IDLE);
  assign mst_address    = addr_q;
  assign mst_write_data = wdata_q;
  assign rx_overrun     = ovr_q;
  // decoded from state flops so an async reset drops it immediately
  assign mst_mode       = (state_q == ST_BUS) ? (op_wr_q ? BUS_WRITE : BUS_READ) : BUS_IDLE;

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    to_cnt_d   = '0;
    ovr_d      = 1'b0;
    ld         = 1'b0;
    ld_data    = '0;
    ld_cnt     = '0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == DBG_OP_READ || rx_data == DBG_OP_WRITE) begin
            op_wr_d    = (rx_data == DBG_OP_WRITE);
            byte_cnt_d = 2'd0;
            state_d    = ST_ADDR;
          end else begin
            ld      = 1'b1;
            ld_data = {24'h0, DBG_RSP_ERR};
            ld_cnt  = 3'd1;
            state_d = ST_RESP;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rx_valid) begin
          if (state_q == ST_ADDR) addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          else                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3)
            state_d = (state_q == ST_ADDR && op_wr_q) ? ST_DATA : ST_BUS;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_BUS: begin
        ovr_d   = rx_valid;
        ld      = 1'b1;
        ld_data = op_wr_q ? {24'h0, DBG_RSP_ACK} : mst_read_data;
        ld_cnt  = op_wr_q ? 3'd1 : 3'd4;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ovr_d = rx_valid;
        if (tx_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      to_cnt_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      to_cnt_q   <= to_cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  dbg_resp_shifter u_resp (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .load_data  (ld_data),
    .load_count (ld_cnt),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last       (tx_last)
  );

endmodule

// File: tb/tb_dbg_bus_master.sv
// tb/tb_dbg_bus_master.sv - directed self-checking bench for dbg_bus_master
module tb_dbg_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] mst_address;
  logic [31:0] mst_write_data;
  logic [1:0]  mst_mode;
  logic [31:0] mst_read_data = 32'h0;
  logic        busy;
  logic        rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int bus_cycles = 0;

  always #5 clk = ~clk;

  dbg_bus_master #(.TIMEOUT_CYCLES(16), .TO_W(17)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .mst_address    (mst_address),
    .mst_write_data (mst_write_data),
    .mst_mode       (mst_mode),
    .mst_read_data  (mst_read_data),
    .busy           (busy),
    .rx_overrun     (rx_overrun)
  );

  always @(negedge clk) if (mst_mode != 2'b00) bus_cycles++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Starts checking at the current negedge; each negedge with tx_valid is one accepted byte.
  task automatic expect_tx(input string tag, input int n, input logic [31:0] exp);
    int got = 0;
    logic [31:0] e = exp;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) begin
        check_eq(tag, {24'h0, tx_data}, {24'h0, e[8*got +: 8]});
        got++;
      end
      if (got == n) break;
      @(negedge clk);
    end
    if (got != n) check_eq({tag, "_count"}, got, n);
  endtask

  initial begin
    int bc;
    int n;
    logic [7:0] held;
    int unstable;

    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mode", mst_mode, 0);
    check_eq("rst_txv", tx_valid, 0);
    check_eq("rst_txd", tx_data, 0);
    check_eq("rst_addr", mst_address, 0);
    check_eq("rst_ovr", rx_overrun, 0);
    @(negedge clk);
    reset = 1'b1;

    // read 0x4104
    mst_read_data = 32'hDEADBEEF;
    bc = bus_cycles;
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    check_eq("rd_mode", mst_mode, 2'b01);
    check_eq("rd_addr", mst_address, 32'h0000_4104);
    @(negedge clk);
    check_eq("rd_mode_off", mst_mode, 0);
    check_eq("rd_lat", tx_valid, 1);
    expect_tx("rd_tx", 4, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("rd_busy", busy, 0);
    check_eq("rd_txv_end", tx_valid, 0);
    check_eq("rd_buscnt", bus_cycles - bc, 1);

    // write 0x12345678 to 0x4108
    bc = bus_cycles;
    send_byte(8'h57); send_byte(8'h08); send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check_eq("wr_mode", mst_mode, 2'b10);
    check_eq("wr_addr", mst_address, 32'h0000_4108);
    check_eq("wr_data", mst_write_data, 32'h1234_5678);
    @(negedge clk);
    expect_tx("wr_tx", 1, 32'h0000_004B);
    @(negedge clk);
    check_eq("wr_busy", busy, 0);
    check_eq("wr_buscnt", bus_cycles - bc, 1);

    // bad opcode
    bc = bus_cycles;
    send_byte(8'h00);
    check_eq("bad_mode", mst_mode, 0);
    expect_tx("bad_tx", 1, 32'h0000_003F);
    @(negedge clk);
    check_eq("bad_busy", busy, 0);
    check_eq("bad_buscnt", bus_cycles - bc, 0);

    // inter-byte timeout after a partial read frame
    bc = bus_cycles;
    send_byte(8'h52); send_byte(8'h04); send_byte(8'h41);
    check_eq("to_busy_mid", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
      if (tx_valid) check_eq("to_no_tx", tx_valid, 0);
    end
    check_eq("to_cycles", n, 16);
    check_eq("to_buscnt", bus_cycles - bc, 0);
    mst_read_data = 32'hCAFEF00D;
    send_byte(8'h52); send_byte(8'h7C); send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    check_eq("to_rd_mode", mst_mode, 2'b01);
    check_eq("to_rd_addr", mst_address, 32'h0000_417C);
    @(negedge clk);
    expect_tx("to_rd_tx", 4, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("to_rd_busy", busy, 0);

    // backpressure with an injected overrun byte
    tx_ready = 1'b0;
    mst_read_data = 32'h11223344;
    bc = bus_cycles;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check_eq("bp_txv", tx_valid, 1);
    check_eq("bp_txd", tx_data, 8'h44);
    held = tx_data;
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        rx_data  = 8'h57;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      if (i == 10) begin
        rx_valid = 1'b0;
        check_eq("ovr_pulse", rx_overrun, 1);
      end
      if (i == 11) check_eq("ovr_clear", rx_overrun, 0);
      if (!tx_valid || tx_data != held) unstable++;
    end
    check_eq("bp_stable", unstable, 0);
    check_eq("bp_busy", busy, 1);
    tx_ready = 1'b1;
    expect_tx("bp_tx", 4, 32'h11223344);
    @(negedge clk);
    check_eq("bp_busy_end", busy, 0);
    check_eq("bp_buscnt", bus_cycles - bc, 1);

    // reset during DATA after two data bytes
    bc = bus_cycles;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h41); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    check_eq("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_mode", mst_mode, 0);
    check_eq("ar_txv", tx_valid, 0);
    check_eq("ar_addr", mst_address, 0);
    check_eq("ar_wdata", mst_write_data, 0);
    @(negedge clk);
    reset = 1'b1;
    send_byte(8'hCC);
    send_byte(8'hDD);
    check_eq("ar_buscnt", bus_cycles - bc, 0);
    check_eq("ar_wdata_after", mst_write_data, 0);
    expect_tx("ar_err_tx", 1, 32'h0000_003F);
    @(negedge clk);
    check_eq("ar_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
